// File: rtl/dmux16_stream.sv
// Stream demultiplexer: steers each input word by in_sel into one of two
// independent per-channel FIFOs (0 = channel A, 1 = channel B), with delivery counters.
module dmux16_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [1:0]       out_ready;
    logic [1:0]       out_valid;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       sel_onehot;
    logic             accept;
    logic [WIDTH-1:0] head_data [2];
    logic [7:0]       count_out [2];

    assign out_ready  = {b_ready, a_ready};
    assign sel_onehot = {in_sel, ~in_sel};

    // A full FIFO still accepts when its head leaves on the same edge.
    assign in_ready = reset_n && (!full[in_sel] || pop[in_sel]);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [OCC_W-1:0] occ_reg;
            logic [7:0]       count_reg;

            assign full[gi]      = (occ_reg == OCC_W'(DEPTH));
            assign out_valid[gi] = (occ_reg != '0);
            assign pop[gi]       = out_valid[gi] && out_ready[gi];
            assign push[gi]      = accept && sel_onehot[gi];
            assign head_data[gi] = out_valid[gi] ? mem[rd_ptr_reg] : '0;
            assign count_out[gi] = count_reg;

            // Storage carries no reset; stale entries are unreachable once occupancy is zero.
            always_ff @(posedge clock) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= in_data;
                end
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        count_reg  <= count_reg + 8'd1;
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   occ_reg <= occ_reg + 1'b1;
                        2'b01:   occ_reg <= occ_reg - 1'b1;
                        default: occ_reg <= occ_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign a_data  = head_data[0];
    assign b_data  = head_data[1];
    assign a_valid = out_valid[0];
    assign b_valid = out_valid[1];
    assign a_count = count_out[0];
    assign b_count = count_out[1];

endmodule
